// File: rtl/logistic_scheduler_pkg.sv
// Shared types and defaults for the logistic-map lane scheduler.
//   state_t   : scheduler FSM states
//   DEF_*     : default geometry (lanes, widths)
//   DEF_SEED  : nominal seed for lane 0
package logistic_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    ITER = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int DEF_LANES = 7;
  localparam int DEF_XW    = 17;
  localparam int DEF_MUW   = 18;
  localparam int DEF_CNTW  = 9;
  localparam int LANE_W    = $clog2(DEF_LANES);

  localparam logic [DEF_XW-1:0] DEF_SEED = 17'h08240;

endpackage

// File: rtl/logistic_scheduler_if.sv
// Bundle between the scheduler and its surroundings: run control, the
// operand/result pair of the shared combinational datapath, and the
// lane read-out port.
//   master : run controller + datapath + reader (drives start/abort/mu/
//            times/dzero_base/lane_sel/func_y)
//   slave  : the scheduler (drives func_x/func_mu/lane_result/busy/done/valid)
interface logistic_scheduler_if #(
  parameter int LANES = 7,
  parameter int XW    = 17,
  parameter int MUW   = 18,
  parameter int CNTW  = 9
);
  localparam int LW = $clog2(LANES);

  logic            start;
  logic            abort;
  logic [MUW-1:0]  mu;
  logic [CNTW-1:0] times;
  logic [XW-1:0]   dzero_base;
  logic [XW-1:0]   func_x;
  logic [MUW-1:0]  func_mu;
  logic [XW-1:0]   func_y;
  logic [LW-1:0]   lane_sel;
  logic [XW-1:0]   lane_result;
  logic            busy;
  logic            done;
  logic            valid;

  modport master (
    output start, abort, mu, times, dzero_base, func_y, lane_sel,
    input  func_x, func_mu, lane_result, busy, done, valid
  );

  modport slave (
    input  start, abort, mu, times, dzero_base, func_y, lane_sel,
    output func_x, func_mu, lane_result, busy, done, valid
  );

endinterface

// File: rtl/logistic_lane_bank.sv
// LANES x XW register file holding one logistic trajectory per lane.
//   seed_en/seed_base : load every lane in parallel with seed_base + i
//   wr_en/wr_idx/wr_data : single indexed write (seed_en has priority)
//   rd_idx/rd_data    : indexed read for the datapath operand
//   peek_idx/peek_data: indexed read for external read-out; out of range -> 0
module logistic_lane_bank #(
  parameter int LANES = 7,
  parameter int XW    = 17,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          seed_en,
  input  logic [XW-1:0] seed_base,
  input  logic          wr_en,
  input  logic [LW-1:0] wr_idx,
  input  logic [XW-1:0] wr_data,
  input  logic [LW-1:0] rd_idx,
  output logic [XW-1:0] rd_data,
  input  logic [LW-1:0] peek_idx,
  output logic [XW-1:0] peek_data
);

  logic [LANES-1:0][XW-1:0] x_q;

  // Seeds wrap modulo 2^XW simply by truncation of the XW-bit sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (seed_en)
          x_q[i] <= seed_base + XW'(i);
        else if (wr_en && (wr_idx == LW'(i)))
          x_q[i] <= wr_data;
      end
    end
  end

  // One extra bit on the compare so LANES == 2^LW still fits.
  always_comb begin
    rd_data   = '0;
    peek_data = '0;
    if ({1'b0, rd_idx} < (LW+1)'(LANES))
      rd_data = x_q[rd_idx];
    if ({1'b0, peek_idx} < (LW+1)'(LANES))
      peek_data = x_q[peek_idx];
  end

endmodule

// File: rtl/logistic_scheduler.sv
// Time-multiplexes one external combinational logistic-map datapath over
// LANES trajectories. A start seeds all lanes, then lanes are stepped
// round-robin (0..LANES-1 per sweep) for `times` sweeps, then done pulses
// and valid marks the lane registers as a complete run.
//   CLK  : rising-edge clock
//   RST  : asynchronous active-low reset
//   bus  : run control, datapath operand/result, lane read-out, status
module logistic_scheduler
  import logistic_scheduler_pkg::*;
#(
  parameter int LANES = 7,
  parameter int XW    = 17,
  parameter int MUW   = 18,
  parameter int CNTW  = 9
) (
  input  logic              CLK,
  input  logic              RST,
  logistic_scheduler_if.slave bus
);

  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  state_t          state_q, state_d;
  logic [MUW-1:0]  mu_q;
  logic [CNTW-1:0] times_q;
  logic [CNTW-1:0] iter_q;
  logic [LW-1:0]   ptr_q;
  logic            done_q;
  logic            valid_q;
  logic [XW-1:0]   bank_rd;

  logic start_ok;
  logic last_step;

  assign start_ok  = (state_q == IDLE) && bus.start;
  // Only evaluated in ITER, where times_q >= 1, so the decrement never wraps.
  assign last_step = (ptr_q == LAST_LANE) && (iter_q == times_q - CNTW'(1));

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; abort only matters while a run is in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = SEED;
      SEED: begin
        if (bus.abort)             state_d = IDLE;
        else if (times_q == '0)    state_d = FIN;
        else                       state_d = ITER;
      end
      ITER: begin
        if (bus.abort)      state_d = IDLE;
        else if (last_step) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; done/valid come straight from flops
  always_comb begin
    bus.busy    = (state_q == SEED) || (state_q == ITER);
    bus.func_x  = (state_q == ITER) ? bank_rd : '0;
    bus.func_mu = mu_q;
    bus.done    = done_q;
    bus.valid   = valid_q;
  end

  // Latched run parameters, lane pointer / sweep counter, status flags.
  // iter_q tops out at times_q on the final wrap, which fits in CNTW bits
  // even for times_q = 2^CNTW-1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mu_q    <= '0;
      times_q <= '0;
      iter_q  <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= (state_q != FIN) && (state_d == FIN);

      if (start_ok) begin
        mu_q    <= bus.mu;
        times_q <= bus.times;
        valid_q <= 1'b0;
      end else if (state_d == FIN) begin
        valid_q <= 1'b1;
      end

      case (state_q)
        SEED: begin
          ptr_q  <= '0;
          iter_q <= '0;
        end
        ITER: begin
          if (ptr_q == LAST_LANE) begin
            ptr_q  <= '0;
            iter_q <= iter_q + CNTW'(1);
          end else begin
            ptr_q  <= ptr_q + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The write lands even in an abort cycle: the datapath result for that
  // lane is already valid, and abort leaves partial values in place.
  logistic_lane_bank #(
    .LANES (LANES),
    .XW    (XW),
    .LW    (LW)
  ) u_bank (
    .clk       (CLK),
    .rst_n     (RST),
    .seed_en   (state_q == SEED),
    .seed_base (bus.dzero_base),
    .wr_en     (state_q == ITER),
    .wr_idx    (ptr_q),
    .wr_data   (bus.func_y),
    .rd_idx    (ptr_q),
    .rd_data   (bank_rd),
    .peek_idx  (bus.lane_sel),
    .peek_data (bus.lane_result)
  );

endmodule

// File: tb/tb_logistic_scheduler.sv
module tb_logistic_scheduler;
  import logistic_scheduler_pkg::*;

  logic CLK;
  logic RST;
  logic real_mode;
  int   total;
  int   bad;

  logistic_scheduler_if bus ();

  logistic_scheduler dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Q0.17 x, Q2.16 mu: y = mu * x * (1 - x)
  function automatic logic [16:0] logmap(input logic [16:0] x, input logic [17:0] m);
    longint p;
    p = longint'(m) * longint'(x) * (longint'(131072) - longint'(x));
    return 17'(p >>> 33);
  endfunction

  always_comb begin
    if (real_mode) bus.func_y = logmap(bus.func_x, bus.func_mu);
    else           bus.func_y = bus.func_x + 17'd1;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Start a run and observe it for a fixed 40-cycle window. inj_k injects a
  // second start plus changed mu/times/dzero_base; abort_k pulses abort.
  task automatic run_seq(input logic [8:0] t, input logic [16:0] d, input logic [17:0] m,
                         input int inj_k, input int abort_k,
                         output int busyc, output int done_at, output int donec,
                         output logic [17:0] mu_mid, output logic busy_post_abort,
                         output logic [16:0] fx2, output logic [16:0] fx3);
    bus.mu = m; bus.times = t; bus.dzero_base = d; bus.start = 1'b1; bus.abort = 1'b0;
    tick;
    bus.start = 1'b0;
    busyc = 0; done_at = 0; donec = 0; mu_mid = '0; busy_post_abort = 1'b1;
    fx2 = '0; fx3 = '0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.busy) busyc++;
      if (bus.done) begin
        donec++;
        if (done_at == 0) done_at = k;
      end
      if (k == 2) fx2 = bus.func_x;
      if (k == 3) fx3 = bus.func_x;
      if (k == 6) mu_mid = bus.func_mu;
      if (abort_k != 0 && k == abort_k + 1) busy_post_abort = bus.busy;
      bus.start = (k == inj_k);
      bus.abort = (k == abort_k);
      if (inj_k != 0 && k == inj_k) begin
        bus.mu = m ^ 18'h3FFFF;
        bus.times = 9'd9;
        bus.dzero_base = d + 17'd100;
      end
      tick;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    #2;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    total++; if (bus.func_x !== 17'h0) begin bad++; $display("FAIL reset_func_x got=%h exp=0", bus.func_x); end
    total++; if (bus.func_mu !== 18'h0) begin bad++; $display("FAIL reset_func_mu got=%h exp=0", bus.func_mu); end
    total++; if (bus.lane_result !== 17'h0) begin bad++; $display("FAIL reset_lane0 got=%h exp=0", bus.lane_result); end
    tick; tick;
    RST = 1'b1;
    tick;
  endtask

  task automatic test_sequencing;
    int bc, da, dc; logic [17:0] mm; logic bpa; logic [16:0] f2, f3;
    logic [16:0] exp_lane [7];
    exp_lane = '{17'h08243, 17'h08244, 17'h08245, 17'h08246, 17'h08247, 17'h08248, 17'h08249};
    run_seq(9'd3, DEF_SEED, 18'h12345, 0, 0, bc, da, dc, mm, bpa, f2, f3);
    total++; if (bc !== 22) begin bad++; $display("FAIL seq_busy_cycles got=%0d exp=22", bc); end
    total++; if (da !== 23) begin bad++; $display("FAIL seq_done_latency got=%0d exp=23", da); end
    total++; if (dc !== 1) begin bad++; $display("FAIL seq_done_count got=%0d exp=1", dc); end
    total++; if (f2 !== 17'h08240) begin bad++; $display("FAIL seq_func_x_first got=%h exp=08240", f2); end
    total++; if (f3 !== 17'h08241) begin bad++; $display("FAIL seq_func_x_second got=%h exp=08241", f3); end
    total++; if (mm !== 18'h12345) begin bad++; $display("FAIL seq_func_mu got=%h exp=12345", mm); end
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%b exp=1", bus.valid); end
    total++; if (bus.func_x !== 17'h0) begin bad++; $display("FAIL seq_func_x_idle got=%h exp=0", bus.func_x); end
    for (int i = 0; i < 7; i++) begin
      bus.lane_sel = 3'(i);
      #1;
      total++;
      if (bus.lane_result !== exp_lane[i]) begin
        bad++; $display("FAIL seq_lane%0d got=%h exp=%h", i, bus.lane_result, exp_lane[i]);
      end
    end
  endtask

  // Also pulses start in the FIN cycle (k=2), which must be ignored.
  task automatic test_zero_iter;
    int bc, da, dc; logic [17:0] mm; logic bpa; logic [16:0] f2, f3;
    logic [16:0] exp_lane [7];
    exp_lane = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001, 17'h00002, 17'h00003, 17'h00004};
    run_seq(9'd0, 17'h1FFFE, 18'h00100, 2, 0, bc, da, dc, mm, bpa, f2, f3);
    total++; if (da !== 2) begin bad++; $display("FAIL zero_done_latency got=%0d exp=2", da); end
    total++; if (dc !== 1) begin bad++; $display("FAIL zero_done_count got=%0d exp=1", dc); end
    total++; if (bc !== 1) begin bad++; $display("FAIL zero_busy_cycles got=%0d exp=1", bc); end
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b exp=1", bus.valid); end
    for (int i = 0; i < 7; i++) begin
      bus.lane_sel = 3'(i);
      #1;
      total++;
      if (bus.lane_result !== exp_lane[i]) begin
        bad++; $display("FAIL zero_lane%0d got=%h exp=%h", i, bus.lane_result, exp_lane[i]);
      end
    end
  endtask

  task automatic test_ignored_start;
    int bc, da, dc; logic [17:0] mm; logic bpa; logic [16:0] f2, f3;
    logic [16:0] exp_lane [7];
    exp_lane = '{17'h00202, 17'h00203, 17'h00204, 17'h00205, 17'h00206, 17'h00207, 17'h00208};
    run_seq(9'd2, 17'h00200, 18'h0ABCD, 5, 0, bc, da, dc, mm, bpa, f2, f3);
    total++; if (da !== 16) begin bad++; $display("FAIL ign_done_latency got=%0d exp=16", da); end
    total++; if (dc !== 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", dc); end
    total++; if (mm !== 18'h0ABCD) begin bad++; $display("FAIL ign_func_mu_mid got=%h exp=0abcd", mm); end
    total++; if (bus.func_mu !== 18'h0ABCD) begin bad++; $display("FAIL ign_func_mu_end got=%h exp=0abcd", bus.func_mu); end
    for (int i = 0; i < 7; i++) begin
      bus.lane_sel = 3'(i);
      #1;
      total++;
      if (bus.lane_result !== exp_lane[i]) begin
        bad++; $display("FAIL ign_lane%0d got=%h exp=%h", i, bus.lane_result, exp_lane[i]);
      end
    end
  endtask

  task automatic test_abort;
    int bc, da, dc; logic [17:0] mm; logic bpa; logic [16:0] f2, f3;
    logic [16:0] exp_lane [7];
    // abort at k=6 = fifth ITER cycle: lanes 0..4 stepped once, 5..6 at seed
    exp_lane = '{17'h00101, 17'h00102, 17'h00103, 17'h00104, 17'h00105, 17'h00105, 17'h00106};
    run_seq(9'd4, 17'h00100, 18'h00777, 0, 6, bc, da, dc, mm, bpa, f2, f3);
    total++; if (bpa !== 1'b0) begin bad++; $display("FAIL abort_busy_next got=%b exp=0", bpa); end
    total++; if (dc !== 0) begin bad++; $display("FAIL abort_done_count got=%0d exp=0", dc); end
    total++; if (bc !== 6) begin bad++; $display("FAIL abort_busy_cycles got=%0d exp=6", bc); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", bus.valid); end
    for (int i = 0; i < 7; i++) begin
      bus.lane_sel = 3'(i);
      #1;
      total++;
      if (bus.lane_result !== exp_lane[i]) begin
        bad++; $display("FAIL abort_lane%0d got=%h exp=%h", i, bus.lane_result, exp_lane[i]);
      end
    end
    run_seq(9'd1, 17'h00000, 18'h00777, 0, 0, bc, da, dc, mm, bpa, f2, f3);
    total++; if (da !== 9) begin bad++; $display("FAIL abort_restart_latency got=%0d exp=9", da); end
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL abort_restart_valid got=%b exp=1", bus.valid); end
    bus.lane_sel = 3'd6;
    #1;
    total++; if (bus.lane_result !== 17'h00007) begin bad++; $display("FAIL abort_restart_lane6 got=%h exp=00007", bus.lane_result); end
  endtask

  task automatic test_async_reset;
    bus.mu = 18'h00042; bus.times = 9'd5; bus.dzero_base = 17'h00010;
    bus.start = 1'b1; bus.lane_sel = 3'd0;
    tick;
    bus.start = 1'b0;
    for (int k = 0; k < 9; k++) tick;
    total++; if (bus.func_x === 17'h0) begin bad++; $display("FAIL arst_pre_func_x got=%h exp=nonzero", bus.func_x); end
    #3;
    RST = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL arst_done got=%b exp=0", bus.done); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", bus.valid); end
    total++; if (bus.lane_result !== 17'h0) begin bad++; $display("FAIL arst_lane0 got=%h exp=0", bus.lane_result); end
    total++; if (bus.func_x !== 17'h0) begin bad++; $display("FAIL arst_func_x got=%h exp=0", bus.func_x); end
    total++; if (bus.func_mu !== 18'h0) begin bad++; $display("FAIL arst_func_mu got=%h exp=0", bus.func_mu); end
    tick;
    RST = 1'b1;
    tick;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL arst_release_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_real_datapath;
    int bc, da, dc; logic [17:0] mm; logic bpa; logic [16:0] f2, f3;
    logic [16:0] expv;
    real_mode = 1'b1;
    run_seq(9'd1, 17'h08000, 18'h30000, 0, 0, bc, da, dc, mm, bpa, f2, f3);
    total++; if (da !== 9) begin bad++; $display("FAIL real_done_latency got=%0d exp=9", da); end
    // 3 * 0.25 * 0.75 = 0.5625 -> 0x12000; seed 0x08001 lands on 0x12001
    bus.lane_sel = 3'd0;
    #1;
    total++; if (bus.lane_result !== 17'h12000) begin bad++; $display("FAIL real_lane0 got=%h exp=12000", bus.lane_result); end
    bus.lane_sel = 3'd1;
    #1;
    total++; if (bus.lane_result !== 17'h12001) begin bad++; $display("FAIL real_lane1 got=%h exp=12001", bus.lane_result); end
    for (int i = 2; i < 7; i++) begin
      bus.lane_sel = 3'(i);
      expv = logmap(17'h08000 + 17'(i), 18'h30000);
      #1;
      total++;
      if (bus.lane_result !== expv) begin
        bad++; $display("FAIL real_lane%0d got=%h exp=%h", i, bus.lane_result, expv);
      end
    end
    bus.lane_sel = 3'd7;
    #1;
    total++; if (bus.lane_result !== 17'h0) begin bad++; $display("FAIL real_lane_sel7 got=%h exp=0", bus.lane_result); end
    real_mode = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    real_mode = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.mu = '0; bus.times = '0; bus.dzero_base = '0; bus.lane_sel = '0;
    test_reset;
    test_sequencing;
    test_zero_iter;
    test_ignored_start;
    test_abort;
    test_async_reset;
    test_real_datapath;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logistic_scheduler.md
Name: logistic_scheduler

Overview:
Time-multiplexes one shared logistic-map datapath across LANES independent trajectories. Each trajectory differs only in its seed.
On a start pulse the block seeds every lane, then runs round-robin iterations until each lane has been mapped `times` times. It then pulses done and holds the results for the pixel/colour logic to read.
The shared datapath stays external and combinational, and the scheduler drives its operands. This replaces one datapath instance per lane.

Parameters:
LANES, 7, number of trajectories sharing the datapath (2..16)
XW, 17, state width (fixed-point x)
MUW, 18, growth-parameter width
CNTW, 9, iteration-count width

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a run; honoured only in IDLE
abort  in  1  terminate a run in progress
mu  in  MUW  growth parameter; sampled on accepted start
times  in  CNTW  iterations per lane; sampled on accepted start
dzero_base  in  XW  seed of lane 0; lane i seeds with (dzero_base + i) mod 2^XW
func_x  out  XW  operand to the shared datapath
func_mu  out  MUW  parameter to the shared datapath (= latched mu)
func_y  in  XW  datapath result, combinational, same cycle as func_x
lane_sel  in  clog2(LANES)  read select
lane_result  out  XW  x of lane lane_sel (combinational read of lane register)
busy  out  1  high in SEED or ITER
done  out  1  one-cycle pulse at run completion
valid  out  1  lane registers hold a complete run

Behaviour:
- Reset (async, RST=0): state=IDLE; all lane regs, mu_q, times_q, lane ptr, iter count = 0; busy=done=valid=0; func_x=0, func_mu=0.
- States: IDLE, SEED, ITER, FIN.
- IDLE:
  - busy=0.
  - start=1: latch mu_q<=mu and times_q<=times; clear valid; go SEED.
- SEED (1 cycle):
  - All lanes load in parallel: x[i] <= dzero_base + i, truncated to XW bits.
  - lane ptr=0, iter=0.
  - If times_q==0 go FIN, else go ITER.
- ITER:
  - Each cycle: func_x = x[ptr]; x[ptr] <= func_y.
  - ptr increments and wraps LANES-1 -> 0. On wrap, iter increments.
  - When ptr==LANES-1 and iter==times_q-1, the update lands and the state goes to FIN.
  - ITER lasts exactly times_q*LANES cycles. Lanes are updated in order 0..LANES-1 per sweep.
- FIN (1 cycle):
  - done=1 and valid<=1, both registered; go IDLE.
  - Latency from the start cycle to the done pulse = 2 + times_q*LANES cycles.
- func_mu = mu_q at all times. func_x = x[ptr] in ITER and 0 otherwise.
- start outside IDLE is ignored (no queueing). start in the FIN cycle is also ignored.
- abort:
  - In SEED or ITER: next state IDLE; no done; valid stays 0; lane regs keep partial values.
  - abort in IDLE/FIN has no effect.
  - abort and start together in IDLE: start wins.
- mu/times/dzero_base changes mid-run have no effect; only the latched copies are used.
- times_q = 2^CNTW-1 is legal and the counter must not overflow. iter and ptr reset each run.
- lane_sel >= LANES returns 0.
- Reset mid-run: immediate IDLE, everything cleared, no done.
- Datapath width rules are the datapath's own. The scheduler never modifies func_y and stores its low XW bits verbatim.

Decomposition:
- Shared package: state enum {IDLE, SEED, ITER, FIN}; LANE_W = clog2(LANES); default seed constant 17'h08240.
- One natural sub-module: logistic_lane_bank, holding the LANES x XW register file with parallel seed, single indexed write and indexed read ports.
- The FSM and counters stay in logistic_scheduler.

Test Plan:
- Sequencing: bench stub func_y = func_x + 1; start with times=3, dzero_base=17'h08240, LANES=7 -> busy for 22 cycles; done exactly 23 cycles after start; lane i = 17'h08243 + i; valid=1.
- Zero iterations: times=0, dzero_base=17'h1FFFE -> done 2 cycles after start; lane0=1FFFE, lane1=1FFFF, lane2=00000 (wrap), lane6=00004.
- Ignored start / latched inputs: second start and mu change mid-run -> no restart; func_mu keeps first mu; done pulses once.
- Abort: abort in ITER cycle 5 with times=4 -> IDLE next cycle, no done, valid=0. Lanes 0..4 incremented once, lanes 5..6 at seed. A fresh start then completes normally.
- Async reset: drop RST mid-ITER without a clock edge -> busy, done, valid, lane_result and func_x go to 0 immediately.
- Real datapath: stub replaced by the logistic map at mu=18'h30000, times=1 -> each lane equals the golden model's single-step value for its seed; lane_sel=7 returns 0.
